// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multiply/divide unit holding the architectural HI/LO registers.
//   MULT/MULTU/MTHI/MTLO complete at the accepting edge. DIV/DIVU run a
//   32-step restoring divider followed by one sign-fix cycle, holding busy high
//   for 33 cycles.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start, op    issue strobe and opcode (sampled only while busy=0)
//   a, b         rs / rt operands
//   flush        abort of an in-flight divide; also drops a start issued in IDLE
//   busy         divide in progress
//   done         one-cycle pulse after a MULT/MULTU/DIV/DIVU writes HI/LO
//   hi, lo       registered HI/LO
module hilo_muldiv (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [31:0] dvd;       // dividend shifts out the top, quotient bits enter the bottom
   logic [31:0] dvs;
   logic [31:0] rem;
   logic [31:0] araw;      // raw dividend, returned in HI on divide by zero
   logic        qneg, rneg, div0;
   logic        done_q;
   logic [31:0] hi_q, lo_q;

   logic        accept, do_mul, do_div, sgn_div;
   logic [63:0] ea, eb, prod;
   logic [32:0] rem_sh, diff;

   assign accept  = (state == S_IDLE) & start & ~flush;
   assign do_mul  = accept & ((op == OP_MULT) | (op == OP_MULTU));
   assign do_div  = accept & ((op == OP_DIV) | (op == OP_DIVU));
   assign sgn_div = (op == OP_DIV);

   // One 64-bit multiplier serves both forms: sign- or zero-extend to 64 bits,
   // the low 64 bits of the product are then correct for either.
   assign ea   = {{32{(op == OP_MULT) & a[31]}}, a};
   assign eb   = {{32{(op == OP_MULT) & b[31]}}, b};
   assign prod = ea * eb;

   // Restoring step: shift in the next dividend bit, trial-subtract the divisor.
   assign rem_sh = {rem, dvd[31]};
   assign diff   = rem_sh - {1'b0, dvs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (do_div) state_nxt = S_DIV;
         S_DIV:   if (flush) state_nxt = S_IDLE;
                  else if (cnt == 5'd31) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         cnt    <= '0;
         dvd    <= '0;
         dvs    <= '0;
         rem    <= '0;
         araw   <= '0;
         qneg   <= 1'b0;
         rneg   <= 1'b0;
         div0   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (do_mul) begin
            hi_q   <= prod[63:32];
            lo_q   <= prod[31:0];
            done_q <= 1'b1;
         end
         if (accept && op == OP_MTHI) hi_q <= a;
         if (accept && op == OP_MTLO) lo_q <= a;
         if (do_div) begin
            dvd  <= (sgn_div & a[31]) ? -a : a;
            dvs  <= (sgn_div & b[31]) ? -b : b;
            rem  <= '0;
            cnt  <= '0;
            araw <= a;
            qneg <= sgn_div & (a[31] ^ b[31]);
            rneg <= sgn_div & a[31];
            div0 <= (b == 32'd0);
         end
         if (state == S_DIV && !flush) begin
            rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
            dvd <= {dvd[30:0], ~diff[32]};
            cnt <= cnt + 5'd1;
         end
         if (state == S_FIX && !flush) begin
            // 0x80000000 / -1 falls out naturally: |q| = 0x80000000, signs agree.
            lo_q   <= div0 ? 32'hFFFF_FFFF : (qneg ? -dvd : dvd);
            hi_q   <= div0 ? araw : (rneg ? -rem : rem);
            done_q <= 1'b1;
         end
      end
   end

   assign busy = (state != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0, b = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int total = 0;
   int bad = 0;

   hilo_muldiv dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // Issue one op, then check timing and results. For divides, a stray MULT
   // start is injected mid-divide and must be ignored.
   task automatic do_op(input vec_t v, input int idx);
      int  n;
      bit  isdiv, ismul;
      isdiv = (v.op == 3'd3) || (v.op == 3'd4);
      ismul = (v.op == 3'd1) || (v.op == 3'd2);
      @(negedge clk);
      start = 1'b1; op = v.op; a = v.a; b = v.b;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      if (isdiv) begin
         n = 0;
         while (busy && n < 100) begin
            n++;
            if (n == 5) begin
               start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
            end else begin
               start = 1'b0; op = 3'd0;
            end
            @(negedge clk);
         end
         start = 1'b0;
         chk($sformatf("v%0d_busy_cycles", idx), n, 33);
      end else begin
         chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd0);
      end
      chk($sformatf("v%0d_done", idx), {31'd0, done}, {31'd0, (isdiv || ismul)});
      chk($sformatf("v%0d_hi", idx), hi, v.hi);
      chk($sformatf("v%0d_lo", idx), lo, v.lo);
      @(negedge clk);
      chk($sformatf("v%0d_done_drop", idx), {31'd0, done}, 32'd0);
   endtask

   initial begin
      // op, a, b, expected hi, expected lo (applied in order; MT* rely on prior state)
      tbl[0] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      tbl[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      tbl[2] = '{3'd5, 32'h12345678, 32'd0,        32'h12345678, 32'h00000001};
      tbl[3] = '{3'd6, 32'hDEADBEEF, 32'd0,        32'h12345678, 32'hDEADBEEF};
      tbl[4] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[5] = '{3'd4, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
      tbl[6] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      tbl[7] = '{3'd4, 32'h80000000, 32'd3,        32'h00000002, 32'h2AAAAAAA};
      tbl[8] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      tbl[9] = '{3'd3, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF};

      #1;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) do_op(tbl[i], i);

      // Back-to-back MULT: done high on each cycle of the run.
      @(negedge clk);
      start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
      @(negedge clk);
      chk("b2b_done1", {31'd0, done}, 32'd1);
      chk("b2b_lo1", lo, 32'd6);
      a = 32'd4; b = 32'hFFFFFFFB;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      chk("b2b_done2", {31'd0, done}, 32'd1);
      chk("b2b_hi2", hi, 32'hFFFFFFFF);
      chk("b2b_lo2", lo, 32'hFFFFFFEC);
      @(negedge clk);
      chk("b2b_done_drop", {31'd0, done}, 32'd0);

      // Reserved op: nothing changes.
      start = 1'b1; op = 3'd7; a = 32'h1; b = 32'h1;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      chk("rsv_busy", {31'd0, busy}, 32'd0);
      chk("rsv_done", {31'd0, done}, 32'd0);
      chk("rsv_lo", lo, 32'hFFFFFFEC);

      // Preload HI/LO, then flush a divide at cycle 10.
      start = 1'b1; op = 3'd5; a = 32'hA5A5A5A5;
      @(negedge clk);
      op = 3'd6;
      @(negedge clk);
      op = 3'd3; a = 32'd1000; b = 32'd7;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      chk("fl_busy_on", {31'd0, busy}, 32'd1);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl_busy", {31'd0, busy}, 32'd0);
      chk("fl_done", {31'd0, done}, 32'd0);
      chk("fl_hi", hi, 32'hA5A5A5A5);
      chk("fl_lo", lo, 32'hA5A5A5A5);
      repeat (30) begin
         @(negedge clk);
         chk("fl_no_done", {31'd0, done}, 32'd0);
      end

      // Flush together with start in IDLE drops the op.
      start = 1'b1; flush = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0; op = 3'd0;
      chk("fls_done", {31'd0, done}, 32'd0);
      chk("fls_lo", lo, 32'hA5A5A5A5);

      // Reset mid-divide: outputs clear immediately.
      start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_hi", hi, 32'd0);
      chk("mrst_lo", lo, 32'd0);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Divider is usable again after reset: 100/7 = 14 r 2.
      do_op('{3'd4, 32'd100, 32'd7, 32'd2, 32'd14}, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multiply/divide unit with architectural HI/LO registers for the 54-instruction MIPS pipeline. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds HI/LO for MFHI/MFLO. The `hi` and `lo` outputs feed two inputs of the 32-bit 8:1 writeback/forwarding source mux downstream. MULT, MULTU, MTHI and MTLO take a single cycle. Divides run for 33 cycles and assert `busy` so the hazard unit stalls the pipeline.

## Interface
- No parameters; all datapaths are fixed at 32 bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe; sampled only when `busy`=0.
- `op`  in  3  operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
- `a`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- `b`  in  32  rt operand: multiplier or divisor.
- `flush`  in  1  synchronous abort of an in-flight divide (exception or branch squash).
- `busy`  out  1  divide in progress; the pipeline must stall any MULT/DIV/MT*/MF* while this is high.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO are written by MULT/MULTU/DIV/DIVU.
- `hi`  out  32  HI register, registered output.
- `lo`  out  32  LO register, registered output.

## Operation
- States:
  - IDLE.
  - DIV: 32 restoring-division iterations, counted 0..31 with a 5-bit counter.
  - FIX: sign correction, then the HI/LO write.
- Any `start` is accepted only in IDLE. It is ignored in DIV and FIX, with no queueing.
- MULT: signed 32x32 -> 64-bit product. HI = product[63:32], LO = product[31:0]. Written at the accepting edge.
- MULTU: same as MULT with unsigned operands.
- MTHI / MTLO: HI (or LO) = `a` at the accepting edge. The other register is unchanged. No `done` pulse.
- DIV / DIVU at the accepting edge:
  - Latch |a| and |b|; for DIVU, use the raw values.
  - Latch the quotient and remainder signs.
  - Clear the remainder accumulator and go to DIV.
- DIV state: each edge shifts one dividend bit into the remainder and performs a trial subtract. The quotient bit is 1 when the subtract result is non-negative. After count 31, go to FIX.
- FIX state: apply signs, write the results, and return to IDLE.
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
- Divide by zero (b=0), DIV or DIVU: LO = 32'hFFFFFFFF and HI = `a` (raw). Same 33-cycle latency.
- Signed overflow, 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- `flush` in DIV or FIX: return to IDLE at the next edge. HI/LO are unchanged and no `done` pulse is produced.
- `flush` in IDLE together with `start`: flush wins and the op is dropped.
- Reserved op or op=000 with `start`: no state change.

## Timing
- Reset, asynchronous on `rst_n`=0: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0. Reset mid-divide discards the operation.
- Call the accepting edge E0.
- MULT/MULTU: `hi`/`lo` show the new value after E0. `done`=1 for the cycle after E0. `busy` stays 0.
- MTHI/MTLO: the new value is visible after E0.
- DIV/DIVU:
  - `busy` rises after E0.
  - Edges E1..E32 perform the iterations.
  - E33 is the FIX edge: it writes `hi`/`lo`, drops `busy`, and raises `done` for one cycle.
  - `busy` is therefore high for exactly 33 cycles.
- A new `start` may be accepted at E33+1, the first edge with `busy`=0.
- Back-to-back MULT on consecutive edges is legal. `done` stays high for each cycle of the run.
- `done` is registered and never asserts combinationally from `start`.

## Test plan
- Reset, then MULT with a=32'hFFFFFFFD (-3), b=5 -> after E0: hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; `done` pulses 1 cycle; `busy` stays 0.
- MULTU with a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. Then MTHI a=32'h12345678 -> hi=32'h12345678, lo unchanged.
- DIV with a=32'hFFFFFFF9 (-7), b=2 -> `busy` high exactly 33 cycles; then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, `done` for 1 cycle. A `start` issued mid-divide is ignored.
- DIVU with a=100, b=0 -> after 33 cycles: lo=32'hFFFFFFFF, hi=32'h00000064.
- DIV with a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0. DIVU with a=32'h80000000, b=3 -> lo=32'h2AAAAAAA, hi=2.
- DIV started with hi=lo=32'hA5A5A5A5; assert `flush` at cycle 10 -> IDLE next edge, busy=0, hi/lo still 32'hA5A5A5A5, no `done`. Repeat with `rst_n` low at cycle 20 -> all outputs 0 immediately.
